bcd_counter_n: RTL and testbench



---
 rtl/bcd_cnt_pkg.sv | 14 +
 rtl/bcd_digit.sv | 39 +++
 rtl/bcd_counter_n.sv | 97 +++++++++
 tb/tb_bcd_counter_n.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_cnt_pkg.sv
// Shared BCD definitions for the N-decade counter: digit type, digit limits
// and the digit validity check used on parallel load.
package bcd_cnt_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;
    localparam bcd_digit_t BCD_MIN = 4'd0;

    function automatic logic bcd_valid(input bcd_digit_t digit);
        return digit <= BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade: next-value and carry/borrow logic for up, down and load.
// Purely combinational; the top level owns the state register.
module bcd_digit
    import bcd_cnt_pkg::*;
(
    input  bcd_digit_t value,
    input  logic       up,
    input  logic       carry_in,
    input  logic       load,
    input  bcd_digit_t load_digit,
    output bcd_digit_t value_next,
    output logic       carry_out
);

    always_comb begin
        value_next = value;
        carry_out  = 1'b0;
        if (load) begin
            value_next = bcd_valid(load_digit) ? load_digit : BCD_MIN;
        end else if (carry_in) begin
            if (up) begin
                if (value >= BCD_MAX) begin
                    value_next = BCD_MIN;
                    carry_out  = 1'b1;
                end else begin
                    value_next = value + 4'd1;
                end
            end else begin
                if (value == BCD_MIN) begin
                    value_next = BCD_MAX;
                    carry_out  = 1'b1;
                end else begin
                    value_next = value - 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/bcd_counter_n.sv
// N-decade up/down BCD counter with load, wrap/saturate policy and cascade TC.
// Display latch register is built only when BCD_CNT_LATCH_EN is defined.
module bcd_counter_n
    import bcd_cnt_pkg::*;
#(
    parameter int unsigned DIGITS = 6,
    parameter bit          WRAP   = 1'b1
) (
    input  logic                  F_IN,
    input  logic                  RST_N,
    input  logic                  ENA,
    input  logic                  CLR,
    input  logic                  UP,
    input  logic                  LOAD,
    input  logic [4*DIGITS-1:0]   D,
    input  logic                  LATCH,
    output logic [4*DIGITS-1:0]   Q,
    output logic [4*DIGITS-1:0]   Q_LAT,
    output logic                  TC,
    output logic                  OVF,
    output logic                  LOAD_ERR
);

    localparam int unsigned W = 4 * DIGITS;

    logic [W-1:0]      q_next;
    logic [DIGITS:0]   carry;
    logic [DIGITS-1:0] digit_bad;
    logic              all_max;
    logic              all_min;

    // ENA seeds the ripple; a carry out of the top decade marks the terminal state
    assign carry[0] = ENA;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_digit u_digit (
            .value      (Q[4*i +: 4]),
            .up         (UP),
            .carry_in   (carry[i]),
            .load       (LOAD),
            .load_digit (D[4*i +: 4]),
            .value_next (q_next[4*i +: 4]),
            .carry_out  (carry[i+1])
        );
        assign digit_bad[i] = !bcd_valid(D[4*i +: 4]);
    end

    always_comb begin
        all_max = 1'b1;
        all_min = 1'b1;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (Q[4*k +: 4] != BCD_MAX) all_max = 1'b0;
            if (Q[4*k +: 4] != BCD_MIN) all_min = 1'b0;
        end
    end

    assign TC = ENA & (UP ? all_max : all_min);

    always_ff @(posedge F_IN or negedge RST_N) begin
        if (!RST_N) begin
            Q        <= '0;
            OVF      <= 1'b0;
            LOAD_ERR <= 1'b0;
        end else begin
            LOAD_ERR <= 1'b0;
            if (CLR) begin
                Q   <= '0;
                OVF <= 1'b0;
            end else if (LOAD) begin
                Q        <= q_next;
                OVF      <= 1'b0;
                LOAD_ERR <= |digit_bad;
            end else if (ENA && carry[DIGITS]) begin
                if (WRAP) Q <= q_next;
                OVF <= 1'b1;
            end else begin
                if (ENA) Q <= q_next;
                if (WRAP) OVF <= 1'b0;
            end
        end
    end

`ifdef BCD_CNT_LATCH_EN
    always_ff @(posedge F_IN or negedge RST_N) begin
        if (!RST_N) begin
            Q_LAT <= '0;
        end else if (LATCH) begin
            Q_LAT <= Q;
        end
    end
`else
    logic unused_latch;
    assign unused_latch = LATCH;
    assign Q_LAT        = Q;
`endif

endmodule

// File: tb/tb_bcd_counter_n.sv
// Directed bench for bcd_counter_n: a 6-digit wrapping instance and a
// 4-digit saturating instance share one clock and reset.
module tb_bcd_counter_n;

    logic        clk;
    logic        rst_n;

    logic        ena_a, clr_a, up_a, load_a, latch_a;
    logic [23:0] d_a, q_a, qlat_a;
    logic        tc_a, ovf_a, lerr_a;

    logic        ena_b, clr_b, up_b, load_b, latch_b;
    logic [15:0] d_b, q_b, qlat_b;
    logic        tc_b, ovf_b, lerr_b;

    int total;
    int bad;

    bcd_counter_n #(.DIGITS(6), .WRAP(1'b1)) u_dut6 (
        .F_IN(clk), .RST_N(rst_n), .ENA(ena_a), .CLR(clr_a), .UP(up_a),
        .LOAD(load_a), .D(d_a), .LATCH(latch_a), .Q(q_a), .Q_LAT(qlat_a),
        .TC(tc_a), .OVF(ovf_a), .LOAD_ERR(lerr_a)
    );

    bcd_counter_n #(.DIGITS(4), .WRAP(1'b0)) u_dut4 (
        .F_IN(clk), .RST_N(rst_n), .ENA(ena_b), .CLR(clr_b), .UP(up_b),
        .LOAD(load_b), .D(d_b), .LATCH(latch_b), .Q(q_b), .Q_LAT(qlat_b),
        .TC(tc_b), .OVF(ovf_b), .LOAD_ERR(lerr_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #2;
        total++; if (q_a !== 24'h000000) begin bad++; $display("FAIL reset_q_a got=%h exp=000000", q_a); end
        total++; if (qlat_a !== 24'h000000) begin bad++; $display("FAIL reset_qlat_a got=%h exp=000000", qlat_a); end
        total++; if (ovf_a !== 1'b0) begin bad++; $display("FAIL reset_ovf_a got=%b exp=0", ovf_a); end
        total++; if (lerr_a !== 1'b0) begin bad++; $display("FAIL reset_lerr_a got=%b exp=0", lerr_a); end
        total++; if (tc_a !== 1'b0) begin bad++; $display("FAIL reset_tc_a got=%b exp=0", tc_a); end
        total++; if (q_b !== 16'h0000) begin bad++; $display("FAIL reset_q_b got=%h exp=0000", q_b); end
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        total++; if (q_a !== 24'h000000) begin bad++; $display("FAIL post_reset_hold got=%h exp=000000", q_a); end
    endtask

    task automatic test_wrap_up;
        up_a = 1'b1; load_a = 1'b1; d_a = 24'h999998;
        tick;
        load_a = 1'b0;
        total++; if (q_a !== 24'h999998) begin bad++; $display("FAIL wrap_load got=%h exp=999998", q_a); end
        total++; if (lerr_a !== 1'b0) begin bad++; $display("FAIL wrap_load_err got=%b exp=0", lerr_a); end
        ena_a = 1'b1;
        #1;
        total++; if (tc_a !== 1'b0) begin bad++; $display("FAIL wrap_tc0 got=%b exp=0", tc_a); end
        tick;
        total++; if (q_a !== 24'h999999) begin bad++; $display("FAIL wrap_q1 got=%h exp=999999", q_a); end
        total++; if (ovf_a !== 1'b0) begin bad++; $display("FAIL wrap_ovf1 got=%b exp=0", ovf_a); end
        total++; if (tc_a !== 1'b1) begin bad++; $display("FAIL wrap_tc1 got=%b exp=1", tc_a); end
        tick;
        total++; if (q_a !== 24'h000000) begin bad++; $display("FAIL wrap_q2 got=%h exp=000000", q_a); end
        total++; if (ovf_a !== 1'b1) begin bad++; $display("FAIL wrap_ovf2 got=%b exp=1", ovf_a); end
        total++; if (tc_a !== 1'b0) begin bad++; $display("FAIL wrap_tc2 got=%b exp=0", tc_a); end
        tick;
        total++; if (q_a !== 24'h000001) begin bad++; $display("FAIL wrap_q3 got=%h exp=000001", q_a); end
        total++; if (ovf_a !== 1'b0) begin bad++; $display("FAIL wrap_ovf3 got=%b exp=0", ovf_a); end
        ena_a = 1'b0; load_a = 1'b1; d_a = 24'h199999;
        tick;
        load_a = 1'b0; ena_a = 1'b1;
        tick;
        ena_a = 1'b0;
        total++; if (q_a !== 24'h200000) begin bad++; $display("FAIL ripple_carry got=%h exp=200000", q_a); end
        total++; if (ovf_a !== 1'b0) begin bad++; $display("FAIL ripple_ovf got=%b exp=0", ovf_a); end
    endtask

    task automatic test_borrow;
        up_a = 1'b0; load_a = 1'b1; d_a = 24'h000100;
        tick;
        load_a = 1'b0; ena_a = 1'b1;
        tick;
        total++; if (q_a !== 24'h000099) begin bad++; $display("FAIL borrow_q1 got=%h exp=000099", q_a); end
        tick;
        total++; if (q_a !== 24'h000098) begin bad++; $display("FAIL borrow_q2 got=%h exp=000098", q_a); end
        ena_a = 1'b0; load_a = 1'b1; d_a = 24'h000000;
        tick;
        load_a = 1'b0;
        #1;
        total++; if (tc_a !== 1'b0) begin bad++; $display("FAIL down_tc_noena got=%b exp=0", tc_a); end
        ena_a = 1'b1;
        #1;
        total++; if (tc_a !== 1'b1) begin bad++; $display("FAIL down_tc got=%b exp=1", tc_a); end
        tick;
        ena_a = 1'b0;
        total++; if (q_a !== 24'h999999) begin bad++; $display("FAIL underflow_q got=%h exp=999999", q_a); end
        total++; if (ovf_a !== 1'b1) begin bad++; $display("FAIL underflow_ovf got=%b exp=1", ovf_a); end
        tick;
        total++; if (ovf_a !== 1'b0) begin bad++; $display("FAIL underflow_ovf_pulse got=%b exp=0", ovf_a); end
        total++; if (q_a !== 24'h999999) begin bad++; $display("FAIL underflow_hold got=%h exp=999999", q_a); end
    endtask

    task automatic test_saturate;
        load_b = 1'b1; d_b = 16'h9999;
        tick;
        load_b = 1'b0; up_b = 1'b1; ena_b = 1'b1;
        #1;
        total++; if (tc_b !== 1'b1) begin bad++; $display("FAIL sat_tc got=%b exp=1", tc_b); end
        for (int n = 0; n < 3; n++) begin
            tick;
            total++; if (q_b !== 16'h9999) begin bad++; $display("FAIL sat_hold_q%0d got=%h exp=9999", n, q_b); end
            total++; if (ovf_b !== 1'b1) begin bad++; $display("FAIL sat_ovf%0d got=%b exp=1", n, ovf_b); end
        end
        clr_b = 1'b1;
        tick;
        clr_b = 1'b0;
        total++; if (q_b !== 16'h0000) begin bad++; $display("FAIL sat_clr_q got=%h exp=0000", q_b); end
        total++; if (ovf_b !== 1'b0) begin bad++; $display("FAIL sat_clr_ovf got=%b exp=0", ovf_b); end
        up_b = 1'b0;
        tick;
        ena_b = 1'b0;
        total++; if (q_b !== 16'h0000) begin bad++; $display("FAIL sat_down_q got=%h exp=0000", q_b); end
        total++; if (ovf_b !== 1'b1) begin bad++; $display("FAIL sat_down_ovf got=%b exp=1", ovf_b); end
        tick;
        total++; if (ovf_b !== 1'b1) begin bad++; $display("FAIL sat_sticky got=%b exp=1", ovf_b); end
        load_b = 1'b1; d_b = 16'h0005;
        tick;
        load_b = 1'b0;
        total++; if (q_b !== 16'h0005) begin bad++; $display("FAIL sat_load_q got=%h exp=0005", q_b); end
        total++; if (ovf_b !== 1'b0) begin bad++; $display("FAIL sat_load_ovf got=%b exp=0", ovf_b); end
    endtask

    task automatic test_load_err;
        load_b = 1'b1; d_b = 16'h12A4;
        tick;
        load_b = 1'b0;
        total++; if (q_b !== 16'h1204) begin bad++; $display("FAIL lerr_q got=%h exp=1204", q_b); end
        total++; if (lerr_b !== 1'b1) begin bad++; $display("FAIL lerr_pulse got=%b exp=1", lerr_b); end
        tick;
        total++; if (lerr_b !== 1'b0) begin bad++; $display("FAIL lerr_clear got=%b exp=0", lerr_b); end
        total++; if (q_b !== 16'h1204) begin bad++; $display("FAIL lerr_hold got=%h exp=1204", q_b); end
        load_b = 1'b1; d_b = 16'hFFFF;
        tick;
        load_b = 1'b0;
        total++; if (q_b !== 16'h0000) begin bad++; $display("FAIL lerr_all_q got=%h exp=0000", q_b); end
        total++; if (lerr_b !== 1'b1) begin bad++; $display("FAIL lerr_all got=%b exp=1", lerr_b); end
    endtask

    task automatic test_priority;
        clr_a = 1'b1; load_a = 1'b1; d_a = 24'h00000F;
        tick;
        clr_a = 1'b0;
        total++; if (q_a !== 24'h000000) begin bad++; $display("FAIL prio_clr_q got=%h exp=000000", q_a); end
        total++; if (lerr_a !== 1'b0) begin bad++; $display("FAIL prio_clr_lerr got=%b exp=0", lerr_a); end
        d_a = 24'h123456; ena_a = 1'b1; up_a = 1'b1;
        tick;
        load_a = 1'b0;
        total++; if (q_a !== 24'h123456) begin bad++; $display("FAIL prio_load_q got=%h exp=123456", q_a); end
        tick;
        ena_a = 1'b0;
        total++; if (q_a !== 24'h123457) begin bad++; $display("FAIL prio_count_q got=%h exp=123457", q_a); end
    endtask

    task automatic test_latch;
        load_a = 1'b1; d_a = 24'h000055; up_a = 1'b1;
        tick;
        load_a = 1'b0; ena_a = 1'b1;
        tick;
        tick;
        ena_a = 1'b0;
        total++; if (q_a !== 24'h000057) begin bad++; $display("FAIL latch_pre_q got=%h exp=000057", q_a); end
        latch_a = 1'b1; clr_a = 1'b1;
        tick;
        latch_a = 1'b0; clr_a = 1'b0;
        total++; if (q_a !== 24'h000000) begin bad++; $display("FAIL latch_clr_q got=%h exp=000000", q_a); end
`ifdef BCD_CNT_LATCH_EN
        total++; if (qlat_a !== 24'h000057) begin bad++; $display("FAIL latch_capture got=%h exp=000057", qlat_a); end
        load_a = 1'b1; d_a = 24'h000042;
        tick;
        load_a = 1'b0;
        total++; if (qlat_a !== 24'h000057) begin bad++; $display("FAIL latch_hold got=%h exp=000057", qlat_a); end
`else
        total++; if (qlat_a !== 24'h000000) begin bad++; $display("FAIL track_clr got=%h exp=000000", qlat_a); end
        load_a = 1'b1; d_a = 24'h000042;
        tick;
        load_a = 1'b0;
        total++; if (qlat_a !== 24'h000042) begin bad++; $display("FAIL track_load got=%h exp=000042", qlat_a); end
`endif
    endtask

    task automatic test_reset_mid;
        load_a = 1'b1; d_a = 24'h000321;
        load_b = 1'b1; d_b = 16'h9999;
        tick;
        load_a = 1'b0; load_b = 1'b0;
        latch_a = 1'b1; ena_b = 1'b1; up_b = 1'b1;
        tick;
        latch_a = 1'b0; ena_b = 1'b0;
        total++; if (q_a !== 24'h000321) begin bad++; $display("FAIL mid_pre_q got=%h exp=000321", q_a); end
        total++; if (ovf_b !== 1'b1) begin bad++; $display("FAIL mid_pre_ovf got=%b exp=1", ovf_b); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (q_a !== 24'h000000) begin bad++; $display("FAIL mid_q_a got=%h exp=000000", q_a); end
        total++; if (qlat_a !== 24'h000000) begin bad++; $display("FAIL mid_qlat_a got=%h exp=000000", qlat_a); end
        total++; if (ovf_a !== 1'b0) begin bad++; $display("FAIL mid_ovf_a got=%b exp=0", ovf_a); end
        total++; if (q_b !== 16'h0000) begin bad++; $display("FAIL mid_q_b got=%h exp=0000", q_b); end
        total++; if (qlat_b !== 16'h0000) begin bad++; $display("FAIL mid_qlat_b got=%h exp=0000", qlat_b); end
        total++; if (ovf_b !== 1'b0) begin bad++; $display("FAIL mid_ovf_b got=%b exp=0", ovf_b); end
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        total++; if (q_a !== 24'h000000) begin bad++; $display("FAIL mid_after_q got=%h exp=000000", q_a); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        ena_a = 1'b0; clr_a = 1'b0; up_a = 1'b1; load_a = 1'b0; latch_a = 1'b0; d_a = '0;
        ena_b = 1'b0; clr_b = 1'b0; up_b = 1'b1; load_b = 1'b0; latch_b = 1'b0; d_b = '0;
        test_reset;
        test_wrap_up;
        test_borrow;
        test_saturate;
        test_load_err;
        test_priority;
        test_latch;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
